// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings and the slot strobe value for the
// traffic-light phase sequencer.
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_MAIN_GREEN  = 3'd0,
        PH_MAIN_YELLOW = 3'd1,
        PH_ALL_RED_A   = 3'd2,
        PH_SIDE_GREEN  = 3'd3,
        PH_SIDE_YELLOW = 3'd4,
        PH_ALL_RED_B   = 3'd5
    } phase_e;

    // Lamp vectors are {R,Y,G}
    localparam logic [2:0] LIGHT_R    = 3'b100;
    localparam logic [2:0] LIGHT_Y    = 3'b010;
    localparam logic [2:0] LIGHT_G    = 3'b001;

    localparam logic [2:0] SLOT_VALUE = 3'd1;

endpackage

// File: rtl/tl_phase_timer.sv
// Loadable down counter measured in slots; it stops at zero and reports it.
module tl_phase_timer #(
    parameter int            TW      = 4,
    parameter logic [TW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    input  logic          slot_i,
    output logic [TW-1:0] value_o,
    output logic          zero_o
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (slot_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/traffic_light_controller.sv
// Main/side intersection phase sequencer driven by the upstream slot counter,
// with side-road demand and a latched pedestrian request.
module traffic_light_controller
    import traffic_pkg::*;
#(
    parameter int GREEN_SLOTS  = 6,
    parameter int YELLOW_SLOTS = 2,
    parameter int RED_SLOTS    = 1,
    parameter int TW           = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    count,
    input  logic          side_sensor,
    input  logic          ped_req,
    output logic [2:0]    main_light,
    output logic [2:0]    side_light,
    output logic          walk,
    output logic          ped_ack,
    output logic [2:0]    phase,
    output logic [TW-1:0] remaining
);

    localparam logic [TW-1:0] GREEN_LOAD  = TW'(GREEN_SLOTS - 1);
    localparam logic [TW-1:0] YELLOW_LOAD = TW'(YELLOW_SLOTS - 1);
    localparam logic [TW-1:0] RED_LOAD    = TW'(RED_SLOTS - 1);

    phase_e        phase_q, phase_d;
    logic          ped_pending_q, ped_pending_d;
    logic          walk_flag_q, walk_flag_d;
    logic          ped_ack_q, ped_ack_d;
    logic          slot, exit_ok, serve;
    logic          timer_load, timer_zero;
    logic [TW-1:0] timer_load_val, timer_val;

    assign slot    = (count == SLOT_VALUE);
    assign exit_ok = slot && timer_zero;

    tl_phase_timer #(
        .TW      (TW),
        .RST_VAL (GREEN_LOAD)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (timer_load_val),
        .slot_i     (slot),
        .value_o    (timer_val),
        .zero_o     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q       <= PH_MAIN_GREEN;
            ped_pending_q <= 1'b0;
            walk_flag_q   <= 1'b0;
            ped_ack_q     <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            ped_pending_q <= ped_pending_d;
            walk_flag_q   <= walk_flag_d;
            ped_ack_q     <= ped_ack_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_MAIN_GREEN:  if (exit_ok && (side_sensor || ped_pending_q)) phase_d = PH_MAIN_YELLOW;
            PH_MAIN_YELLOW: if (exit_ok) phase_d = PH_ALL_RED_A;
            PH_ALL_RED_A:   if (exit_ok) phase_d = PH_SIDE_GREEN;
            PH_SIDE_GREEN:  if (exit_ok) phase_d = PH_SIDE_YELLOW;
            PH_SIDE_YELLOW: if (exit_ok) phase_d = PH_ALL_RED_B;
            PH_ALL_RED_B:   if (exit_ok) phase_d = PH_MAIN_GREEN;
            default:        phase_d = PH_MAIN_GREEN;
        endcase

        // Any phase change, including recovery from an illegal code, reloads the timer
        timer_load = (phase_d != phase_q);
        case (phase_d)
            PH_MAIN_GREEN, PH_SIDE_GREEN:   timer_load_val = GREEN_LOAD;
            PH_MAIN_YELLOW, PH_SIDE_YELLOW: timer_load_val = YELLOW_LOAD;
            default:                        timer_load_val = RED_LOAD;
        endcase

        serve         = ped_pending_q && (phase_d == PH_SIDE_GREEN) && (phase_q != PH_SIDE_GREEN);
        ped_pending_d = ped_req || (ped_pending_q && !serve);
        ped_ack_d     = serve;
        walk_flag_d   = walk_flag_q;
        if (serve) begin
            walk_flag_d = 1'b1;
        end else if (phase_d != PH_SIDE_GREEN) begin
            walk_flag_d = 1'b0;
        end
    end

    always_comb begin
        main_light = LIGHT_R;
        side_light = LIGHT_R;
        case (phase_q)
            PH_MAIN_GREEN:  main_light = LIGHT_G;
            PH_MAIN_YELLOW: main_light = LIGHT_Y;
            PH_SIDE_GREEN:  side_light = LIGHT_G;
            PH_SIDE_YELLOW: side_light = LIGHT_Y;
            default: ;
        endcase
        walk      = walk_flag_q && (phase_q == PH_SIDE_GREEN);
        ped_ack   = ped_ack_q;
        phase     = phase_q;
        remaining = timer_val;
    end

endmodule
